// File: rtl/lpf_settle_controller.sv
// rtl/lpf_settle_controller.sv - sequences a low-pass filter baseline through reset, settling and convergence qualification
module lpf_settle_controller #(
    parameter int INIT_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 1024,
    parameter int TOL           = 16,
    parameter int STABLE_CYCLES = 8,
    parameter int MAX_CHECK     = 4096,
    parameter int CNT_W         = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ch_enable,
    input  logic               restart,
    input  logic               hold,
    input  logic signed [15:0] x,
    input  logic signed [15:0] y,
    output logic               lpf_reset,
    output logic               lpf_enable,
    output logic               settled,
    output logic [2:0]         state,
    output logic [7:0]         restart_count,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_RUN    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_N    = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CHECK_N     = CNT_W'(MAX_CHECK);
    localparam logic [16:0]      TOL_U       = 17'(TOL);

    state_t           st;
    state_t           nxt;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] check_cnt;
    logic             en_q;
    logic             lpf_reset_q;
    logic             settled_q;
    logic             take_restart;
    logic             timeout;
    logic             entering;

    // 17-bit difference cannot overflow, and its magnitude (max 65535) fits unsigned 17 bits
    logic signed [16:0] diff;
    logic        [16:0] mag;
    logic               is_stable;
    logic [CNT_W-1:0]   stable_inc;
    logic [CNT_W-1:0]   check_inc;

    assign diff       = {x[15], x} - {y[15], y};
    assign mag        = diff[16] ? 17'(-diff) : 17'(diff);
    assign is_stable  = (mag <= TOL_U);
    assign stable_inc = stable_cnt + 1'b1;
    assign check_inc  = check_cnt + 1'b1;

    always_comb begin
        nxt          = st;
        take_restart = 1'b0;
        timeout      = 1'b0;
        if (st != S_IDLE && !ch_enable) begin
            nxt = S_IDLE;
        end else if (st != S_IDLE && restart) begin
            nxt          = S_INIT;
            take_restart = 1'b1;
        end else begin
            case (st)
                S_IDLE:   if (ch_enable) nxt = S_INIT;
                S_INIT:   if (phase_cnt == INIT_LAST) nxt = S_SETTLE;
                S_SETTLE: if (!hold && phase_cnt == SETTLE_LAST) nxt = S_CHECK;
                S_CHECK: begin
                    if (!hold) begin
                        if (is_stable && stable_inc == STABLE_N) begin
                            nxt = S_RUN;
                        end else if (check_inc == CHECK_N) begin
                            nxt     = S_INIT;
                            timeout = 1'b1;
                        end
                    end
                end
                default:  nxt = st;
            endcase
        end
    end

    // A restart while already in INIT is a re-entry and must clear the counters too
    assign entering = (nxt != st) || take_restart;

    always_ff @(posedge clk) begin
        if (!reset) begin
            st            <= S_IDLE;
            lpf_reset_q   <= 1'b1;
            en_q          <= 1'b0;
            settled_q     <= 1'b0;
            restart_count <= 8'd0;
            err           <= 1'b0;
            phase_cnt     <= '0;
            stable_cnt    <= '0;
            check_cnt     <= '0;
        end else begin
            st          <= nxt;
            lpf_reset_q <= (nxt == S_IDLE) || (nxt == S_INIT);
            en_q        <= (nxt == S_SETTLE) || (nxt == S_CHECK) || (nxt == S_RUN);
            settled_q   <= (nxt == S_RUN);
            if (timeout) err <= 1'b1;
            if (take_restart && restart_count != 8'hFF) restart_count <= restart_count + 8'd1;
            if (entering) begin
                phase_cnt  <= '0;
                stable_cnt <= '0;
                check_cnt  <= '0;
            end else begin
                case (st)
                    S_INIT:   phase_cnt <= phase_cnt + 1'b1;
                    S_SETTLE: if (!hold) phase_cnt <= phase_cnt + 1'b1;
                    S_CHECK: begin
                        if (!hold) begin
                            stable_cnt <= is_stable ? stable_inc : '0;
                            check_cnt  <= check_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Enable is state-qualified by a register and gated by hold in the same cycle
    assign lpf_enable = en_q & ~hold;
    assign lpf_reset  = lpf_reset_q;
    assign settled    = settled_q;
    assign state      = st;

endmodule

// File: tb/tb_lpf_settle_controller.sv
// tb/tb_lpf_settle_controller.sv - directed table-driven bench for lpf_settle_controller
module tb_lpf_settle_controller;

    logic               clk = 1'b0;
    logic               reset;
    logic               ch_enable;
    logic               restart;
    logic               hold;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic               lpf_reset;
    logic               lpf_enable;
    logic               settled;
    logic [2:0]         state;
    logic [7:0]         restart_count;
    logic               err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lpf_settle_controller #(
        .INIT_CYCLES(4), .SETTLE_CYCLES(8), .TOL(16),
        .STABLE_CYCLES(3), .MAX_CHECK(20), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .ch_enable(ch_enable), .restart(restart),
        .hold(hold), .x(x), .y(y), .lpf_reset(lpf_reset), .lpf_enable(lpf_enable),
        .settled(settled), .state(state), .restart_count(restart_count), .err(err)
    );

    typedef struct {
        int               n;
        bit               ce;
        bit               rs;
        bit               hd;
        logic signed [15:0] xv;
        logic signed [15:0] yv;
        int               st;
        bit               lr;
        bit               le;
        bit               se;
        int               rc;
        bit               er;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input bit ce, input bit rs, input bit hd,
                       input int xv, input int yv, input int st, input bit lr,
                       input bit le, input bit se, input int rc, input bit er);
        vec_t v;
        v.n = n; v.ce = ce; v.rs = rs; v.hd = hd;
        v.xv = 16'(xv); v.yv = 16'(yv);
        v.st = st; v.lr = lr; v.le = le; v.se = se; v.rc = rc; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int st, input bit lr, input bit le,
                                 input bit se, input int rc, input bit er);
        chk({tag, ".state"}, int'(state), st);
        chk({tag, ".lpf_reset"}, int'(lpf_reset), int'(lr));
        chk({tag, ".lpf_enable"}, int'(lpf_enable), int'(le));
        chk({tag, ".settled"}, int'(settled), int'(se));
        chk({tag, ".restart_count"}, int'(restart_count), rc);
        chk({tag, ".err"}, int'(err), int'(er));
    endtask

    // Each record covers n cycles: inputs held for the cycle, outputs checked mid-cycle
    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                ch_enable = vecs[i].ce; restart = vecs[i].rs; hold = vecs[i].hd;
                x = vecs[i].xv; y = vecs[i].yv;
                @(negedge clk);
                check_outputs($sformatf("vec%0d.%0d", i, k), vecs[i].st, vecs[i].lr,
                              vecs[i].le, vecs[i].se, vecs[i].rc, vecs[i].er);
                @(posedge clk); #1;
            end
        end
    endtask

    int s_nom, s_hold, s_tol, s_sat, s_end;

    initial begin
        // Nominal bring-up: IDLE, INIT x4, SETTLE x8, CHECK x3, RUN
        s_nom = vecs.size();
        add(1, 1,0,0, 1000,1000, 0, 1,0,0, 0,0);
        add(4, 1,0,0, 1000,1000, 1, 1,0,0, 0,0);
        add(8, 1,0,0, 1000,1000, 2, 0,1,0, 0,0);
        add(3, 1,0,0, 1000,1000, 3, 0,1,0, 0,0);
        add(3, 1,0,0, 1000,1000, 4, 0,1,1, 0,0);
        // Restart in RUN, then hold 5 cycles mid-SETTLE, hold in RUN, priority, IDLE restart
        s_hold = vecs.size();
        add(1, 1,1,0, 1000,1000, 4, 0,1,1, 0,0);
        add(4, 1,0,0, 1000,1000, 1, 1,0,0, 1,0);
        add(3, 1,0,0, 1000,1000, 2, 0,1,0, 1,0);
        add(5, 1,0,1, 1000,1000, 2, 0,0,0, 1,0);
        add(5, 1,0,0, 1000,1000, 2, 0,1,0, 1,0);
        add(3, 1,0,0, 1000,1000, 3, 0,1,0, 1,0);
        add(1, 1,0,0, 1000,1000, 4, 0,1,1, 1,0);
        add(2, 1,0,1, 1000,1000, 4, 0,0,1, 1,0);
        add(1, 1,1,0, 1000,1000, 4, 0,1,1, 1,0);
        add(4, 1,0,0, 1000,1000, 1, 1,0,0, 2,0);
        add(2, 1,0,0, 1000,1000, 2, 0,1,0, 2,0);
        add(1, 0,1,0, 1000,1000, 2, 0,1,0, 2,0);
        add(2, 0,0,0, 1000,1000, 0, 1,0,0, 2,0);
        add(2, 0,1,0, 1000,1000, 0, 1,0,0, 2,0);
        // a=17 times out after 20 CHECK cycles; retry at a=16 with one unstable sample reaches RUN
        s_tol = vecs.size();
        add(1, 1,1,0, 1000,1017, 0, 1,0,0, 2,0);
        add(4, 1,0,0, 1000,1017, 1, 1,0,0, 2,0);
        add(8, 1,0,0, 1000,1017, 2, 0,1,0, 2,0);
        add(20,1,0,0, 1000,1017, 3, 0,1,0, 2,0);
        add(4, 1,0,0, 1000,1016, 1, 1,0,0, 2,1);
        add(8, 1,0,0, 1000,1016, 2, 0,1,0, 2,1);
        add(2, 1,0,0, 1000,1016, 3, 0,1,0, 2,1);
        add(1, 1,0,0, 1000,1017, 3, 0,1,0, 2,1);
        add(3, 1,0,0, 1000,1016, 3, 0,1,0, 2,1);
        add(2, 1,0,0, 1000,1016, 4, 0,1,1, 2,1);
        // Extreme difference must never look stable
        add(1, 1,1,0, -32768,32767, 4, 0,1,1, 2,1);
        add(4, 1,0,0, -32768,32767, 1, 1,0,0, 3,1);
        add(8, 1,0,0, -32768,32767, 2, 0,1,0, 3,1);
        add(20,1,0,0, -32768,32767, 3, 0,1,0, 3,1);
        add(1, 1,0,0, -32768,32767, 1, 1,0,0, 3,1);
        // After saturating restarts: full bring-up with count pinned at 255
        s_sat = vecs.size();
        add(4, 1,0,0, 1000,1000, 1, 1,0,0, 255,1);
        add(8, 1,0,0, 1000,1000, 2, 0,1,0, 255,1);
        add(3, 1,0,0, 1000,1000, 3, 0,1,0, 255,1);
        add(2, 1,0,0, 1000,1000, 4, 0,1,1, 255,1);
        s_end = vecs.size();

        reset = 1'b0; ch_enable = 1'b0; restart = 1'b0; hold = 1'b0; x = 16'sd0; y = 16'sd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_outputs("reset", 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;

        run_vecs(s_nom, s_sat);

        restart = 1'b1; ch_enable = 1'b1; x = 16'sd1000; y = 16'sd1000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("restart_count_after_10", int'(restart_count), 13);
        @(posedge clk); #1;
        for (int i = 0; i < 290; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("restart_count_saturated", int'(restart_count), 255);
        chk("state_during_restarts", int'(state), 1);
        @(posedge clk); #1;
        restart = 1'b0;
        run_vecs(s_sat, s_end);

        // One-cycle reset in RUN with err set; the full sequence must repeat from IDLE
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        run_vecs(s_nom, s_hold);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
